// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan sequencer: captures a 4-bit value, splits it into
// tens/ones and time-multiplexes both digits onto one segment bus with blank gaps.
module seg_scan_ctrl #(
    parameter int TICK_DIV       = 4,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] value_in,
    input  logic       value_valid,
    output logic       value_ready,
    output logic [7:0] seg,
    output logic [1:0] dig_sel,
    output logic       frame_done,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Handshake: value_in is captured on the rising edge where value_valid && value_ready
    // && !clear; value_ready depends on the current state only, never on value_valid.

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ONES = 3'd1,
        GAP1 = 3'd2,
        TENS = 3'd3,
        GAP2 = 3'd4
    } state_t;

    localparam int            CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
    localparam logic [7:0]    BLANK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    val_q, val_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    logic          capture;
    logic          tens_z;
    logic [3:0]    ones_v;
    logic [7:0]    raw_seg;

    function automatic logic [7:0] pat(input logic [3:0] d);
        case (d)
            4'd0:    pat = 8'h3F;
            4'd1:    pat = 8'h06;
            4'd2:    pat = 8'h5B;
            4'd3:    pat = 8'h4F;
            4'd4:    pat = 8'h66;
            4'd5:    pat = 8'h6D;
            4'd6:    pat = 8'h7D;
            4'd7:    pat = 8'h07;
            4'd8:    pat = 8'h7F;
            4'd9:    pat = 8'h6F;
            default: pat = 8'h00;
        endcase
    endfunction

    assign value_ready = (state_q == IDLE) || (state_q == GAP2);
    assign capture     = value_valid && value_ready && !clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_d = ONES;
                        val_d   = value_in;
                        cnt_d   = '0;
                    end
                end
                ONES: begin
                    if (cnt_q == LAST) begin
                        state_d = GAP1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                GAP1: begin
                    state_d = TENS;
                    cnt_d   = '0;
                end
                TENS: begin
                    if (cnt_q == LAST) begin
                        state_d = GAP2;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                GAP2: begin
                    state_d = ONES;
                    cnt_d   = '0;
                    if (capture) val_d = value_in;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state and value so the registered copies line up
    // with the state they describe.
    always_comb begin
        tens_z  = (val_d > 4'd9);
        ones_v  = tens_z ? (val_d - 4'd10) : val_d;
        raw_seg = 8'h00;
        dig_d   = 2'b00;
        case (state_d)
            ONES: begin
                dig_d   = 2'b01;
                raw_seg = pat(ones_v);
            end
            TENS: begin
                dig_d   = 2'b10;
                raw_seg = (BLANK_LZ && !tens_z) ? 8'h00 : pat({3'b000, tens_z});
            end
            default: begin
                dig_d   = 2'b00;
                raw_seg = 8'h00;
            end
        endcase
        seg_d        = SEG_ACTIVE_LOW ? ~raw_seg : raw_seg;
        frame_done_d = (state_d == GAP2);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            val_q        <= 4'd0;
            seg_q        <= BLANK;
            dig_q        <= 2'b00;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            val_q        <= val_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: default instance (TICK_DIV=4) plus an inverted, no-blanking
// instance (TICK_DIV=2) used for the full 0..15 sweep.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_a = 1'b0, valid_a = 1'b0, clear_b = 1'b0, valid_b = 1'b0;
    logic [3:0] value_a = 4'd0, value_b = 4'd0;
    logic       ready_a, fd_a, busy_a, ready_b, fd_b, busy_b;
    logic [7:0] seg_a, seg_b;
    logic [1:0] dig_a, dig_b;
    logic [2:0] st_a, st_b;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  ones_seen = 8'hEE;
    logic [7:0]  tens_seen = 8'hEE;

    typedef struct {
        logic [3:0] v;
        logic [7:0] ones;
        logic [7:0] tens;
    } vec_t;
    vec_t tbl[6];

    seg_scan_ctrl #(.TICK_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clear(clear_a), .value_in(value_a), .value_valid(valid_a),
        .value_ready(ready_a), .seg(seg_a), .dig_sel(dig_a), .frame_done(fd_a),
        .busy(busy_a), .dbg_state(st_a)
    );

    seg_scan_ctrl #(.TICK_DIV(2), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b), .value_in(value_b), .value_valid(valid_b),
        .value_ready(ready_b), .seg(seg_b), .dig_sel(dig_b), .frame_done(fd_b),
        .busy(busy_b), .dbg_state(st_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tb_pat(input int d);
        logic [7:0] t[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        return t[d];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive a value until ready, then let one capture edge pass; returns at the negedge
    // of the first ONES cycle. The expectation is queued after the capture edge.
    task automatic load(input bit b, input logic [3:0] v, input bit push,
                        input logic [15:0] e, output int waited);
        waited = 0;
        if (b) begin valid_b = 1'b1; value_b = v; end
        else   begin valid_a = 1'b1; value_a = v; end
        while (!(b ? ready_b : ready_a) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_timeout", (waited < 50), 1);
        @(posedge clk);
        #1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd_a && n < 100);
        check("frame_done_timeout", (n < 100), 1);
    endtask

    // Scoreboard: collect the digits shown during each frame, compare at frame_done.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst || !busy_a) begin
            ones_seen = 8'hEE;
            tens_seen = 8'hEE;
        end else begin
            if (dig_a == 2'b01) ones_seen = seg_a;
            if (dig_a == 2'b10) tens_seen = seg_a;
            if (fd_a && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_digits", {ones_seen, tens_seen}, e);
                ones_seen = 8'hEE;
                tens_seen = 8'hEE;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;
        logic [7:0] ex;
        tbl[0] = '{4'd10, 8'h3F, 8'h06};
        tbl[1] = '{4'd0,  8'h3F, 8'h00};
        tbl[2] = '{4'd15, 8'h6D, 8'h06};
        tbl[3] = '{4'd3,  8'h4F, 8'h00};
        tbl[4] = '{4'd12, 8'h5B, 8'h06};
        tbl[5] = '{4'd8,  8'h7F, 8'h00};

        repeat (2) @(negedge clk);
        check("rst_seg_a", seg_a, 8'h00);
        check("rst_dig_a", dig_a, 2'b00);
        check("rst_fd_busy_ready_a", {fd_a, busy_a, ready_a}, 3'b001);
        check("rst_seg_b", seg_b, 8'hFF);
        check("rst_ready_b", ready_b, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_stays", {busy_a, dig_a, ready_a}, 4'b0001);

        // Load 7: exact per-cycle frame timing.
        load(1'b0, 4'd7, 1'b1, {8'h07, 8'h00}, w);
        for (int i = 1; i <= 10; i++) begin
            check("f7_dig", dig_a, (i <= 4) ? 2'b01 : (i == 5) ? 2'b00 : (i <= 9) ? 2'b10 : 2'b00);
            check("f7_seg", seg_a, (i <= 4) ? 8'h07 : 8'h00);
            check("f7_fd_ready_busy", {fd_a, ready_a, busy_a}, {(i == 10), (i == 10), 1'b1});
            if (i < 10) @(negedge clk);
        end

        // Load 13 and verify the rescan repeats every frame.
        load(1'b0, 4'd13, 1'b1, {8'h4F, 8'h06}, w);
        wait_fd(n);
        @(negedge clk);
        check("rescan_ones", {dig_a, seg_a}, {2'b01, 8'h4F});
        repeat (5) @(negedge clk);
        check("rescan_tens", {dig_a, seg_a}, {2'b10, 8'h06});
        wait_fd(n);
        check("rescan_tail_len", n, 4);
        wait_fd(n);
        check("frame_len", n, 10);

        // Value 9 presented mid-TENS must wait for GAP2.
        n = 0;
        while (dig_a != 2'b10 && n < 20) begin @(negedge clk); n++; end
        load(1'b0, 4'd9, 1'b1, {8'h6F, 8'h00}, w);
        check("mid_tens_wait", (w >= 1 && w <= 5), 1);

        for (int i = 0; i < 6; i++)
            load(1'b0, tbl[i].v, 1'b1, {tbl[i].ones, tbl[i].tens}, w);
        wait_fd(n);
        #1;
        check("queue_drained", exp_q.size(), 0);

        // clear and valid together in GAP2: clear wins.
        clear_a = 1'b1; valid_a = 1'b1; value_a = 4'd5;
        @(negedge clk);
        check("clr_out", {dig_a, seg_a}, {2'b00, 8'h00});
        check("clr_fd_busy_ready", {fd_a, busy_a, ready_a}, 3'b001);
        clear_a = 1'b0; valid_a = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_idle", {busy_a, dig_a}, 3'b000);

        // Reset in the middle of ONES blanks at once.
        load(1'b0, 4'd3, 1'b0, 16'h0, w);
        @(negedge clk);
        check("pre_rst_ones", dig_a, 2'b01);
        rst = 1'b1;
        #1;
        check("mid_rst_out", {seg_a, dig_a}, {8'h00, 2'b00});
        check("mid_rst_fd_busy_ready", {fd_a, busy_a, ready_a}, 3'b001);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Inverted polarity, no leading-zero blanking, full sweep.
        for (int v = 0; v < 16; v++) begin
            load(1'b1, 4'(v), 1'b0, 16'h0, w);
            ex = ~tb_pat(v % 10);
            check("inv_ones", {dig_b, seg_b}, {2'b01, ex});
            repeat (2) @(negedge clk);
            check("inv_gap", {dig_b, seg_b}, {2'b00, 8'hFF});
            @(negedge clk);
            ex = ~tb_pat(v / 10);
            check("inv_tens", {dig_b, seg_b}, {2'b10, ex});
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
